// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_seq_state_t;

  localparam int unsigned NIBBLE_W = 4;

endpackage

// File: rtl/adder_cla_4bit.sv
// 4-bit carry-lookahead adder slice with carry-out and signed-overflow flag.
module adder_cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       ovfl
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Lookahead carries, all derived directly from cin.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign s    = w_p ^ w_c[3:0];
  assign cout = w_c[4];
  assign ovfl = w_c[4] ^ w_c[3];

endmodule

// File: rtl/adder_seq_16bit.sv
// Multi-cycle adder/subtractor: one shared 4-bit CLA slice, one nibble per cycle,
// LSB nibble first, with start/busy/done handshake and carry/overflow/zero flags.
module adder_seq_16bit
  import adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovfl,
  output logic             zero
);

  localparam int unsigned NSLICE = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned PART_W = WIDTH - NIBBLE_W;

  adder_seq_state_t r_state;
  adder_seq_state_t w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [IDX_W-1:0]    r_idx;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic                r_carry;
  logic [PART_W-1:0]   r_partial;

  logic                r_busy;
  logic                r_done;
  logic [WIDTH-1:0]    r_s;
  logic                r_cout;
  logic                r_ovfl;
  logic                r_zero;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;
  logic                w_ovfl;
  logic [WIDTH-1:0]    w_result;

  assign w_last   = (r_idx == IDX_W'(NSLICE - 1));
  assign w_result = {w_sum, r_partial};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; a start is only honoured from IDLE or DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Select operand nibble i for the shared slice.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int unsigned n = 0; n < NSLICE; n++) begin
      if (r_idx == IDX_W'(n)) begin
        w_a_nib = r_a[n*NIBBLE_W +: NIBBLE_W];
        w_b_nib = r_b[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  adder_cla_4bit u_slice (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout),
    .ovfl (w_ovfl)
  );

  // Operand capture, nibble accumulation and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_partial <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_s       <= '0;
      r_cout    <= 1'b0;
      r_ovfl    <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == RUN);
      r_done <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= sub;
        r_idx   <= '0;
      end else if (r_state == RUN) begin
        r_carry <= w_cout;
        for (int unsigned n = 0; n < NSLICE - 1; n++) begin
          if (r_idx == IDX_W'(n)) begin
            r_partial[n*NIBBLE_W +: NIBBLE_W] <= w_sum;
          end
        end
        if (w_last) begin
          r_s    <= w_result;
          r_cout <= w_cout;
          r_ovfl <= w_ovfl;
          r_zero <= (w_result == '0);
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign s    = r_s;
  assign cout = r_cout;
  assign ovfl = r_ovfl;
  assign zero = r_zero;

endmodule

// File: tb/tb_adder_seq_16bit.sv
// Self-checking bench for adder_seq_16bit: directed handshake cases plus
// randomized back-to-back operations against a timeline/arithmetic model.
module tb_adder_seq_16bit;

  localparam int NSL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        cout;
  logic        ovfl;
  logic        zero;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  adder_seq_16bit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .ovfl  (ovfl),
    .zero  (zero)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // {ovfl, cout, s} straight from the arithmetic definition.
  function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                          input logic op);
    logic [15:0] ye;
    logic [16:0] sum;
    logic        ov;
    ye  = op ? ~y : y;
    sum = {1'b0, x} + {1'b0, ye} + {16'd0, op};
    ov  = (x[15] == ye[15]) && (sum[15] != x[15]);
    return {ov, sum};
  endfunction

  // Model: an accepted op occupies NSLICE cycles, then publishes its result with done.
  int          m_rem;
  logic        m_done;
  logic [15:0] m_s;
  logic        m_cout;
  logic        m_ovfl;
  logic        m_zero;
  logic [17:0] m_pend;

  always @(posedge clk) begin
    if (rst) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_s    <= '0;
      m_cout <= 1'b0;
      m_ovfl <= 1'b0;
      m_zero <= 1'b0;
      m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_s    <= m_pend[15:0];
          m_cout <= m_pend[16];
          m_ovfl <= m_pend[17];
          m_zero <= (m_pend[15:0] == 16'd0);
          m_done <= 1'b1;
        end
      end
      if (m_rem == 0 && start) begin
        m_pend <= ref_add(a, b, sub);
        m_rem  <= NSL;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_rem != 0));
      check("done", 32'(done), 32'(m_done));
      check("s",    32'(s),    32'(m_s));
      check("cout", 32'(cout), 32'(m_cout));
      check("ovfl", 32'(ovfl), 32'(m_ovfl));
      check("zero", 32'(zero), 32'(m_zero));
    end
  end

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic set_op(input logic [15:0] x, input logic [15:0] y, input logic op);
    start = 1'b1;
    a     = x;
    b     = y;
    sub   = op;
  endtask

  // Waits (bounded) for done; optionally scribbles on inputs while the op runs.
  task automatic wait_done(output int lat, input bit noise);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (noise) begin
        start = 1'($urandom);
        a     = 16'($urandom);
        b     = 16'($urandom);
        sub   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end while (!done && lat < 20);
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [15:0] es, input logic ec,
                           input logic eo, input logic ez);
    check({tag, "_s"},    32'(s),      32'(es));
    check({tag, "_cout"}, 32'(cout),   32'(ec));
    check({tag, "_ovfl"}, 32'(ovfl),   32'(eo));
    check({tag, "_zero"}, 32'(zero),   32'(ez));
    check({tag, "_mdl"},  32'(m_s),    32'(es));
  endtask

  task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic op, input logic [15:0] es, input logic ec,
                       input logic eo, input logic ez);
    int lat;
    @(negedge clk);
    set_op(x, y, op);
    wait_done(lat, 1'b0);
    check({tag, "_lat"}, 32'(lat), 32'd5);
    check_res(tag, es, ec, eo, ez);
  endtask

  initial begin
    int lat;
    int ndone;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    sub   = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0);

    do_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op("wrap",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    do_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    do_op("borrow",  16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

    // start pulsed during RUN must be ignored
    @(negedge clk);
    set_op(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    set_op(16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ign_ndone", 32'(ndone), 32'd1);
    check_res("ign", 16'h2345, 1'b0, 1'b0, 1'b0);

    // back-to-back: second start issued in the DONE cycle
    @(negedge clk);
    set_op(16'h0F0F, 16'hF0F0, 1'b0);
    wait_done(lat, 1'b0);
    check_res("b2b1", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    set_op(16'h00FF, 16'h00FF, 1'b1);
    wait_done(lat, 1'b0);
    check("b2b2_lat", 32'(lat), 32'd5);
    check_res("b2b2", 16'h0000, 1'b1, 1'b0, 1'b1);

    // reset during the second RUN cycle discards the op
    @(negedge clk);
    set_op(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check_res("mrst", 16'h0000, 1'b0, 1'b0, 1'b0);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mrst_ndone", 32'(ndone), 32'd0);
    do_op("after", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);

    // randomized back-to-back traffic with occasional start noise during RUN
    @(negedge clk);
    set_op(pick(), pick(), 1'($urandom));
    for (int i = 0; i < 10000; i++) begin
      wait_done(lat, (i % 4) == 0);
      check("rnd_lat", 32'(lat), 32'd5);
      if (i < 9999) begin
        set_op(pick(), pick(), 1'($urandom));
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
